// File: rtl/pk_hasti.sv
// Shared HASTI (AHB-Lite) types: transfer kinds, response codes, demux slave selects.
// No logic of its own; zero latency.
// Carries no flow control; it only defines the encodings the bus blocks agree on.
package pk_hasti;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_S0   = 2'd1,
    SEL_S1   = 2'd2,
    SEL_DEF  = 2'd3
  } slave_sel_t;

  // Only NONSEQ and SEQ move data; IDLE and BUSY get a zero-wait OKAY.
  function automatic logic trans_active(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/if_hasti_slave_io.sv
// HASTI slave-side bundle: address/control/write data one way, read data/response the other.
// Pure wiring, zero latency.
// hready/hreadyout carry the wait-state handshake between master and slave.
interface if_hasti_slave_io;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hsel;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hreadyout;

  // Near side: the block holding this modport behaves as the slave.
  modport n (
    input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hsel, hready,
    output hrdata, hresp, hreadyout
  );

  // Far side: the block holding this modport drives a slave.
  modport f (
    output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hsel, hready,
    input  hrdata, hresp, hreadyout
  );
endinterface

// File: rtl/hasti_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle AHB ERROR response.
// Registered response: ERR1 (wait + ERROR) the cycle after the access, then ERR2 (ready + ERROR).
// Inserts exactly one wait state per unmapped access; otherwise always ready with OKAY.
module hasti_default_slave
  import pk_hasti::*;
(
  input  logic hclk,
  input  logic hresetn,
  input  logic acc,
  output logic hreadyout,
  output logic hresp
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Next state: an access in ERR2 restarts the error sequence directly.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = acc ? ST_ERR1 : ST_IDLE;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = acc ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, cleared immediately by reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  assign hreadyout = (state != ST_ERR1);
  assign hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/hasti_slave_demux.sv
// Address decoder + response mux: one HASTI slave port fanned out to two slaves plus a default slave.
// Zero added latency: decode is combinational, response is muxed in the data phase by a registered select.
// Selected slave's hreadyout stalls upstream; upstream hready is broadcast so both slaves see the stall.
module hasti_slave_demux
  import pk_hasti::*;
#(
  parameter logic [31:0] BASE0 = 32'h0000_0000,
  parameter logic [31:0] MASK0 = 32'hF000_0000,
  parameter logic [31:0] BASE1 = 32'h1000_0000,
  parameter logic [31:0] MASK1 = 32'hF000_0000
) (
  input logic            hclk,
  input logic            hresetn,
  if_hasti_slave_io.n    in,
  if_hasti_slave_io.f    out0,
  if_hasti_slave_io.f    out1
);

  logic       hit0;
  logic       hit1;
  slave_sel_t asel;
  slave_sel_t dsel;
  logic       def_acc;
  logic       def_hreadyout;
  logic       def_hresp;

  assign hit0 = (in.haddr & MASK0) == BASE0;
  assign hit1 = (in.haddr & MASK1) == BASE1;

  // Address-phase select; window 0 wins when both windows match.
  always_comb begin
    asel = SEL_NONE;
    if (in.hsel) begin
      if (hit0)      asel = SEL_S0;
      else if (hit1) asel = SEL_S1;
      else           asel = SEL_DEF;
    end
  end

  // Request side is a straight broadcast; only hsel is steered.
  assign out0.haddr     = in.haddr;
  assign out0.hwrite    = in.hwrite;
  assign out0.hsize     = in.hsize;
  assign out0.hburst    = in.hburst;
  assign out0.hprot     = in.hprot;
  assign out0.htrans    = in.htrans;
  assign out0.hmastlock = in.hmastlock;
  assign out0.hwdata    = in.hwdata;
  assign out0.hready    = in.hready;
  assign out0.hsel      = (asel == SEL_S0);

  assign out1.haddr     = in.haddr;
  assign out1.hwrite    = in.hwrite;
  assign out1.hsize     = in.hsize;
  assign out1.hburst    = in.hburst;
  assign out1.hprot     = in.hprot;
  assign out1.htrans    = in.htrans;
  assign out1.hmastlock = in.hmastlock;
  assign out1.hwdata    = in.hwdata;
  assign out1.hready    = in.hready;
  assign out1.hsel      = (asel == SEL_S1);

  // Data-phase select: advances only when the current data phase completes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)       dsel <= SEL_NONE;
    else if (in.hready) dsel <= asel;
  end

  assign def_acc = (asel == SEL_DEF) && in.hready && trans_active(htrans_t'(in.htrans));

  hasti_default_slave u_default_slave (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .acc       (def_acc),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp)
  );

  // Response mux; no selection reads as an idle, ready, OKAY slave.
  always_comb begin
    in.hrdata    = 32'h0;
    in.hresp     = HRESP_OKAY;
    in.hreadyout = 1'b1;
    case (dsel)
      SEL_S0: begin
        in.hrdata    = out0.hrdata;
        in.hresp     = out0.hresp;
        in.hreadyout = out0.hreadyout;
      end
      SEL_S1: begin
        in.hrdata    = out1.hrdata;
        in.hresp     = out1.hresp;
        in.hreadyout = out1.hreadyout;
      end
      SEL_DEF: begin
        in.hresp     = def_hresp;
        in.hreadyout = def_hreadyout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hasti_slave_demux.sv
module tb_hasti_slave_demux;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] M0 = 32'hF000_0000;
  localparam logic [31:0] B1 = 32'h1000_0000;
  localparam logic [31:0] M1 = 32'hF000_0000;
  localparam logic [31:0] IDLE_DATA = 32'hBAD0_0000;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  if_hasti_slave_io ui ();
  if_hasti_slave_io uo0 ();
  if_hasti_slave_io uo1 ();
  if_hasti_slave_io ov_in ();
  if_hasti_slave_io ov_o0 ();
  if_hasti_slave_io ov_o1 ();

  hasti_slave_demux #(.BASE0(B0), .MASK0(M0), .BASE1(B1), .MASK1(M1)) dut (
    .hclk(hclk), .hresetn(hresetn), .in(ui), .out0(uo0), .out1(uo1));

  hasti_slave_demux #(.BASE0(32'h0), .MASK0(M0), .BASE1(32'h0), .MASK1(M1)) dut_ovl (
    .hclk(hclk), .hresetn(hresetn), .in(ov_in), .out0(ov_o0), .out1(ov_o1));

  // Single master: hready is the mux output looped back.
  assign ui.hready = ui.hreadyout;

  assign ov_o0.hreadyout = 1'b1;
  assign ov_o0.hresp     = 1'b0;
  assign ov_o0.hrdata    = 32'h0;
  assign ov_o1.hreadyout = 1'b1;
  assign ov_o1.hresp     = 1'b0;
  assign ov_o1.hrdata    = 32'h0;

  int checks = 0;
  int fails  = 0;
  logic mon_en = 1'b1;
  logic [31:0] dp_wdata = 32'h0;

  typedef struct {
    int          tgt;    // 0 none, 1 slave0, 2 slave1, 3 unmapped
    logic [31:0] rdata;
    logic        resp;
    int          waits;
    logic        write;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];

  // Behaviour of the two bench slaves: data and wait count derived from the address.
  function automatic logic [31:0] slave_data(input int k, input logic [31:0] a);
    if (k == 0) return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_A5A5);
    return a ^ 32'h3C3C_3C3C;
  endfunction

  function automatic int slave_waits(input logic [31:0] a);
    return 2 * int'((a >> 4) & 32'h3);
  endfunction

  // Reference model: who answers and how, from the decode rules.
  function automatic exp_t model(input logic sel, input logic [31:0] a, input logic [1:0] tr,
                                 input logic wr, input logic [31:0] wd);
    exp_t e;
    logic act;
    act = (tr == 2'b10) || (tr == 2'b11);
    if (!sel)                  e.tgt = 0;
    else if ((a & M0) == B0)   e.tgt = 1;
    else if ((a & M1) == B1)   e.tgt = 2;
    else                       e.tgt = 3;
    e.rdata = 32'h0; e.resp = 1'b0; e.waits = 0; e.wdata = wd;
    e.write = wr && act && (e.tgt == 1 || e.tgt == 2);
    if (e.tgt == 1 || e.tgt == 2) begin
      if (act) begin
        e.waits = slave_waits(a);
        e.rdata = slave_data(e.tgt - 1, a);
      end else begin
        e.rdata = IDLE_DATA;
      end
    end else if (e.tgt == 3 && act) begin
      e.resp = 1'b1;
      e.waits = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench slave models (slave 0 and slave 1).
  logic        s_pend  [2];
  logic [2:0]  s_cnt   [2];
  logic [31:0] s_addr  [2];
  logic        s_hsel  [2];
  logic        s_hready[2];
  logic [1:0]  s_trans [2];
  logic [31:0] s_haddr [2];

  assign s_hsel[0] = uo0.hsel;   assign s_hsel[1] = uo1.hsel;
  assign s_hready[0] = uo0.hready; assign s_hready[1] = uo1.hready;
  assign s_trans[0] = uo0.htrans; assign s_trans[1] = uo1.htrans;
  assign s_haddr[0] = uo0.haddr;  assign s_haddr[1] = uo1.haddr;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int k = 0; k < 2; k++) begin
        s_pend[k] <= 1'b0;
        s_cnt[k]  <= 3'd0;
        s_addr[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_pend[k] && s_cnt[k] != 3'd0) begin
          s_cnt[k] <= s_cnt[k] - 3'd1;
        end else if (s_hready[k] && s_hsel[k] && s_trans[k][1]) begin
          s_pend[k] <= 1'b1;
          s_addr[k] <= s_haddr[k];
          s_cnt[k]  <= 3'(slave_waits(s_haddr[k]));
        end else begin
          s_pend[k] <= 1'b0;
        end
      end
    end
  end

  assign uo0.hreadyout = !s_pend[0] || (s_cnt[0] == 3'd0);
  assign uo0.hrdata    = s_pend[0] ? slave_data(0, s_addr[0]) : IDLE_DATA;
  assign uo0.hresp     = 1'b0;
  assign uo1.hreadyout = !s_pend[1] || (s_cnt[1] == 3'd0);
  assign uo1.hrdata    = s_pend[1] ? slave_data(1, s_addr[1]) : IDLE_DATA;
  assign uo1.hresp     = 1'b0;

  // Drive one address phase, wait for acceptance, then queue its expected data phase.
  task automatic issue(input logic sel, input logic [31:0] a, input logic [1:0] tr,
                       input logic wr, input logic [31:0] wd);
    int guard;
    exp_t e;
    @(negedge hclk);
    ui.hsel = sel; ui.haddr = a; ui.htrans = tr; ui.hwrite = wr;
    ui.hsize = 3'd2; ui.hburst = 3'($urandom_range(0, 7)); ui.hprot = 4'($urandom_range(0, 15));
    ui.hmastlock = 1'b0;
    ui.hwdata = dp_wdata;
    guard = 0;
    while (ui.hready !== 1'b1 && guard < 64) begin
      @(negedge hclk);
      guard++;
    end
    if (guard >= 64) begin
      checks++; fails++;
      $display("FAIL accept_timeout addr=%h waited=%0d cycles", a, guard);
    end
    e = model(sel, a, tr, wr, wd);
    #1;
    chk("addr_out0_hsel", 32'(uo0.hsel), 32'(e.tgt == 1));
    chk("addr_out1_hsel", 32'(uo1.hsel), 32'(e.tgt == 2));
    @(posedge hclk);
    if (mon_en) sbq.push_back(e);
    dp_wdata = wd;
  endtask

  // Monitor: follows the data phase at the head of the scoreboard.
  initial begin : monitor
    int wcnt;
    exp_t e;
    wcnt = 0;
    forever begin
      @(negedge hclk);
      #2;
      if (!mon_en) begin
        wcnt = 0;
      end else if (sbq.size() > 0) begin
        e = sbq[0];
        if (ui.hreadyout === 1'b0) begin
          wcnt++;
          if (e.resp && wcnt == 1) chk("err_first_cycle_hresp", 32'(ui.hresp), 32'd1);
          if (wcnt > 40) begin
            checks++; fails++;
            $display("FAIL data_phase_timeout waits=%0d expected=%0d", wcnt, e.waits);
            void'(sbq.pop_front());
            wcnt = 0;
          end
        end else begin
          void'(sbq.pop_front());
          chk("wait_states", 32'(wcnt), 32'(e.waits));
          chk("hresp", 32'(ui.hresp), 32'(e.resp));
          if (!e.resp) chk("hrdata", ui.hrdata, e.rdata);
          if (e.write) chk("hwdata_at_slave", (e.tgt == 1) ? uo0.hwdata : uo1.hwdata, e.wdata);
          wcnt = 0;
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] r;
    logic [31:0] a;
    logic [2:0]  t;
    logic [1:0]  tr;
    ui.hsel = 1'b0; ui.haddr = 32'h0; ui.htrans = 2'b00; ui.hwrite = 1'b0;
    ui.hsize = 3'd2; ui.hburst = 3'd0; ui.hprot = 4'd0; ui.hmastlock = 1'b0; ui.hwdata = 32'h0;
    ov_in.hsel = 1'b0; ov_in.haddr = 32'h0; ov_in.htrans = 2'b00; ov_in.hwrite = 1'b0;
    ov_in.hsize = 3'd2; ov_in.hburst = 3'd0; ov_in.hprot = 4'd0; ov_in.hmastlock = 1'b0;
    ov_in.hwdata = 32'h0; ov_in.hready = 1'b1;

    repeat (3) @(negedge hclk);
    chk("reset_hreadyout", 32'(ui.hreadyout), 32'd1);
    chk("reset_hresp", 32'(ui.hresp), 32'd0);
    chk("reset_hrdata", ui.hrdata, 32'h0);
    hresetn = 1'b1;

    // Directed sequences from the plan.
    issue(1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 32'h1000_0010, 2'b10, 1'b1, 32'h1234_5678);
    issue(1'b1, 32'h2000_0000, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 32'h0000_0000, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 32'h1000_0000, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 32'h3000_0000, 2'b00, 1'b0, 32'h0);
    issue(1'b1, 32'h2000_0004, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 32'h3000_0008, 2'b11, 1'b1, 32'hCAFE_0001);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      a = {2'b00, r[29:28], 20'h0, r[7:2], 2'b00};
      t = 3'($urandom_range(0, 7));
      tr = (t == 3'd0) ? 2'b00 : (t == 3'd1) ? 2'b01 : {1'b1, t[0]};
      issue($urandom_range(0, 9) != 0, a, tr, r[31], $urandom);
    end
    repeat (3) issue(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    repeat (2) @(negedge hclk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    // Reset asserted during ERR1 of an unmapped access.
    mon_en = 1'b0;
    issue(1'b1, 32'h2000_0000, 2'b10, 1'b0, 32'h0);
    #2;
    chk("err1_hreadyout", 32'(ui.hreadyout), 32'd0);
    chk("err1_hresp", 32'(ui.hresp), 32'd1);
    hresetn = 1'b0;
    #1;
    chk("async_reset_hreadyout", 32'(ui.hreadyout), 32'd1);
    chk("async_reset_hresp", 32'(ui.hresp), 32'd0);
    @(negedge hclk);
    ui.hsel = 1'b0; ui.htrans = 2'b00;
    @(negedge hclk);
    hresetn = 1'b1;
    mon_en = 1'b1;
    issue(1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'h0);
    issue(1'b1, 32'h1000_0020, 2'b10, 1'b0, 32'h0);
    repeat (2) issue(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    repeat (2) @(negedge hclk);
    #3;
    chk("post_reset_drained", 32'(sbq.size()), 32'd0);

    // Overlapping windows: window 0 has priority.
    ov_in.hsel = 1'b1; ov_in.haddr = 32'h0000_0008; ov_in.htrans = 2'b10;
    #1;
    chk("overlap_out0_hsel", 32'(ov_o0.hsel), 32'd1);
    chk("overlap_out1_hsel", 32'(ov_o1.hsel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
